// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared widths and FSM state type for the cache-line to DRAM burst adaptor.
package adaptor_pkg;

   localparam int LINE_W   = 256;
   localparam int BEAT_W   = 64;
   localparam int BEATS    = 4;
   localparam int OFFSET_W = 5;
   localparam int ADDR_W   = 32;
   localparam int CNT_W    = 2;

   localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = ~{{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Bridges a 256-bit line port to a 64-bit, four-beat DRAM burst port.
// Optional protocol checker (sticky proto_err_o) is built when ADAPTOR_PROTO_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for a line request; write has priority over read
// RD    | collecting four read beats into the line buffer
// WR    | presenting four write beats from the line buffer
// DONE  | one-cycle line response, line_o valid
module cacheline_burst_adaptor
   import adaptor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LINE_W-1:0] line_i,
   output logic [LINE_W-1:0] line_o,
   input  logic [ADDR_W-1:0] address_i,
   input  logic              read_i,
   input  logic              write_i,
   output logic              resp_o,
   input  logic [BEAT_W-1:0] burst_i,
   output logic [BEAT_W-1:0] burst_o,
   output logic [ADDR_W-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
`ifdef ADAPTOR_PROTO_CHECK_EN
   ,
   output logic              proto_err_o
`endif
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] buf_q, buf_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      line_d  = line_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (write_i) begin
               buf_d   = line_i;
               addr_d  = address_i & ADDR_ALIGN_MASK;
               cnt_d   = '0;
               state_d = WR;
            end else if (read_i) begin
               addr_d  = address_i & ADDR_ALIGN_MASK;
               cnt_d   = '0;
               state_d = RD;
            end
         end
         RD: begin
            if (resp_i) begin
               buf_d[{cnt_q, 6'd0} +: BEAT_W] = burst_i;
               cnt_d = cnt_q + 2'd1;
               // final beat: publish the freshly completed buffer, counter wraps to 0
               if (cnt_q == 2'd3) begin
                  line_d  = buf_d;
                  state_d = DONE;
               end
            end
         end
         WR: begin
            if (resp_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  line_d  = buf_q;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      read_o    = (state_q == RD);
      write_o   = (state_q == WR);
      resp_o    = (state_q == DONE);
      address_o = addr_q;
      line_o    = line_q;
      burst_o   = '0;
      if (state_q == WR) begin
         burst_o = buf_q[{cnt_q, 6'd0} +: BEAT_W];
      end
   end

`ifdef ADAPTOR_PROTO_CHECK_EN
   logic              proto_err_q, proto_err_d;
   logic [ADDR_W-1:0] addr_raw_q, addr_raw_d;
   logic              busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err_q <= 1'b0;
         addr_raw_q  <= '0;
      end else begin
         proto_err_q <= proto_err_d;
         addr_raw_q  <= addr_raw_d;
      end
   end

   // unaligned request address is kept so offset-bit changes are also caught
   always_comb begin
      busy        = (state_q == RD) || (state_q == WR);
      addr_raw_d  = addr_raw_q;
      proto_err_d = proto_err_q;
      if ((state_q == IDLE) && (write_i || read_i)) begin
         addr_raw_d = address_i;
      end
      if (!busy && resp_i) begin
         proto_err_d = 1'b1;
      end
      if (busy && !read_i && !write_i) begin
         proto_err_d = 1'b1;
      end
      if (busy && (address_i != addr_raw_q)) begin
         proto_err_d = 1'b1;
      end
   end

   assign proto_err_o = proto_err_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Randomised self-checking bench for cacheline_burst_adaptor; expectations come from beat queues and cycle arithmetic.
module tb_cacheline_burst_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;
`ifdef ADAPTOR_PROTO_CHECK_EN
   logic         proto_err_o;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   cacheline_burst_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
`ifdef ADAPTOR_PROTO_CHECK_EN
      ,
      .proto_err_o (proto_err_o)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One line transaction. Starts at a negedge; if fresh, drives the request in that cycle,
   // otherwise the request is assumed already held in the current IDLE cycle.
   // Returns at the negedge of the expected resp_o cycle.
   task automatic run_burst(input bit wr, input bit fresh, input bit hold_rd,
                            input logic [31:0] a, input logic [255:0] data, input int gaps[4]);
      int t0;
      int g;
      logic [31:0] exp_a;
      exp_a = {a[31:5], 5'b0};
      if (fresh) begin
         @(negedge clk);
         address_i = a;
         resp_i    = 1'b0;
         if (wr) begin
            write_i = 1'b1;
            read_i  = hold_rd;
            line_i  = data;
         end else begin
            read_i  = 1'b1;
            write_i = 1'b0;
         end
      end
      t0 = cyc;
      g  = 0;
      @(negedge clk);
      checks++;
      if (read_o !== !wr || write_o !== wr || address_o !== exp_a) begin
         errors++;
         $display("FAIL req_start: read_o=%b write_o=%b address_o=%h required read_o=%b write_o=%b address_o=%h",
                  read_o, write_o, address_o, !wr, wr, exp_a);
      end
`ifndef ADAPTOR_PROTO_CHECK_EN
      address_i = $urandom;
`endif
      resp_i = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         g += gaps[i];
         repeat (gaps[i]) begin
            resp_i = 1'b0;
            @(negedge clk);
         end
         checks++;
         if (resp_o !== 1'b0 || address_o !== exp_a || read_o !== !wr || write_o !== wr) begin
            errors++;
            $display("FAIL beat%0d_ctl: resp_o=%b address_o=%h read_o=%b write_o=%b required resp_o=0 address_o=%h read_o=%b write_o=%b",
                     i, resp_o, address_o, read_o, write_o, exp_a, !wr, wr);
         end
         if (wr) begin
            checks++;
            if (burst_o !== data[i*64 +: 64]) begin
               errors++;
               $display("FAIL wr_beat%0d: burst_o=%h required %h", i, burst_o, data[i*64 +: 64]);
            end
            burst_i = {$urandom, $urandom};
         end else begin
            burst_i = data[i*64 +: 64];
         end
         resp_i = 1'b1;
         @(negedge clk);
      end
      resp_i    = 1'b0;
      address_i = a;
      checks++;
      if (resp_o !== 1'b1 || (cyc - t0) !== 6 + g || read_o !== 1'b0 || write_o !== 1'b0) begin
         errors++;
         $display("FAIL resp_timing: resp_o=%b at T+%0d read_o=%b write_o=%b required resp_o=1 at T+%0d",
                  resp_o, cyc - t0, read_o, write_o, 6 + g);
      end
      if (!wr) begin
         checks++;
         if (line_o !== data) begin
            errors++;
            $display("FAIL rd_line: line_o=%h required %h", line_o, data);
         end
      end
   endtask

   // Cycle after resp_o: requester drops its requests; response must not repeat.
   task automatic after_resp(input bit chk_line, input logic [255:0] exp_line);
      @(negedge clk);
      read_i  = 1'b0;
      write_i = 1'b0;
      checks++;
      if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
         errors++;
         $display("FAIL post_resp: resp_o=%b read_o=%b write_o=%b required 0 0 0", resp_o, read_o, write_o);
      end
      if (chk_line) begin
         checks++;
         if (line_o !== exp_line) begin
            errors++;
            $display("FAIL line_hold: line_o=%h required %h", line_o, exp_line);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      line_i = '0; address_i = '0; burst_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000 || burst_o !== '0 || line_o !== '0 || address_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rd=%b wr=%b resp=%b burst_o=%h line_o=%h address_o=%h required all 0",
                  read_o, write_o, resp_o, burst_o, line_o, address_o);
      end
`ifdef ADAPTOR_PROTO_CHECK_EN
      checks++;
      if (proto_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_proto: proto_err_o=%b required 0", proto_err_o);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_directed_read();
      int gz[4];
      logic [255:0] d;
      gz = '{0, 0, 0, 0};
      d  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      run_burst(1'b0, 1'b1, 1'b0, 32'h0000_1234, d, gz);
      after_resp(1'b1, d);
   endtask

   task automatic test_directed_write();
      int gz[4];
      logic [255:0] d;
      gz = '{0, 1, 0, 0};
      d  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      run_burst(1'b1, 1'b1, 1'b0, 32'hABCD_EF1F, d, gz);
      after_resp(1'b0, '0);
   endtask

   task automatic test_gap_read();
      int gz[4];
      logic [255:0] d;
      gz = '{0, 0, 2, 0};
      d  = rand_line();
      run_burst(1'b0, 1'b1, 1'b0, 32'h8000_0040, d, gz);
      after_resp(1'b1, d);
   endtask

   task automatic test_back_to_back();
      int gz[4];
      logic [255:0] wd, rd;
      logic [31:0] a;
      gz = '{0, 0, 0, 0};
      wd = rand_line();
      rd = rand_line();
      a  = $urandom;
      run_burst(1'b1, 1'b1, 1'b1, a, wd, gz);
      @(negedge clk);
      write_i = 1'b0;
      checks++;
      if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: resp_o=%b read_o=%b write_o=%b required 0 0 0", resp_o, read_o, write_o);
      end
      run_burst(1'b0, 1'b0, 1'b0, a, rd, gz);
      after_resp(1'b1, rd);
   endtask

   task automatic test_mid_reset();
      int gz[4];
      logic [255:0] d;
      @(negedge clk);
      read_i = 1'b1; address_i = 32'h0000_5000; resp_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         resp_i  = 1'b1;
         burst_i = {$urandom, $urandom};
         @(negedge clk);
      end
      rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000 || burst_o !== '0 || line_o !== '0 || address_o !== '0) begin
         errors++;
         $display("FAIL mid_reset: rd=%b wr=%b resp=%b burst_o=%h line_o=%h address_o=%h required all 0",
                  read_o, write_o, resp_o, burst_o, line_o, address_o);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_o !== 1'b0 || read_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: resp_o=%b read_o=%b required 0 0", resp_o, read_o);
      end
      gz = '{1, 0, 0, 1};
      d  = rand_line();
      run_burst(1'b0, 1'b1, 1'b0, 32'h0000_5008, d, gz);
      after_resp(1'b1, d);
   endtask

   task automatic test_random();
      int gz[4];
      logic [255:0] d;
      logic [255:0] last_line;
      bit wr;
      last_line = line_o;
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 4; i++) gz[i] = $urandom_range(0, 3);
         wr = $urandom_range(0, 1);
         d  = rand_line();
         run_burst(wr, 1'b1, 1'b0, $urandom, d, gz);
         if (!wr) last_line = d;
         after_resp(!wr, last_line);
      end
   endtask

   task automatic test_idle_resp();
      int gz[4];
      logic [255:0] d;
      @(negedge clk);
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
      resp_i = 1'b0;
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000) begin
         errors++;
         $display("FAIL idle_resp_ignored: rd=%b wr=%b resp=%b required 0 0 0", read_o, write_o, resp_o);
      end
`ifdef ADAPTOR_PROTO_CHECK_EN
      checks++;
      if (proto_err_o !== 1'b1) begin
         errors++;
         $display("FAIL proto_set: proto_err_o=%b required 1", proto_err_o);
      end
`endif
      gz = '{0, 0, 0, 0};
      d  = rand_line();
      run_burst(1'b0, 1'b1, 1'b0, 32'h0000_0100, d, gz);
      after_resp(1'b1, d);
`ifdef ADAPTOR_PROTO_CHECK_EN
      checks++;
      if (proto_err_o !== 1'b1) begin
         errors++;
         $display("FAIL proto_sticky: proto_err_o=%b required 1", proto_err_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (proto_err_o !== 1'b0) begin
         errors++;
         $display("FAIL proto_clear: proto_err_o=%b required 0", proto_err_o);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_directed_read();
      test_directed_write();
      test_gap_read();
      test_back_to_back();
      test_mid_reset();
      test_random();
`ifdef ADAPTOR_PROTO_CHECK_EN
      checks++;
      if (proto_err_o !== 1'b0) begin
         errors++;
         $display("FAIL proto_clean_traffic: proto_err_o=%b required 0", proto_err_o);
      end
`endif
      test_idle_resp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
